// File: rtl/biometrics_pkg.sv
// Shared encodings for the biometrics feature path.
// Mode codes, aggregator states and a width helper.
package biometrics_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STREAM  = 2'b01;
  localparam logic [1:0] MODE_AVERAGE = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/feature_aggregator.sv
// Collects DCT frames, keeps a coefficient window, streams or averages it.
// Optional FEATURE_LAST_EN adds feature_last_out on the final word.
module feature_aggregator
  import biometrics_pkg::*;
#(
  parameter int N_DCT      = 32,
  parameter int FIRST_COEF = 1,
  parameter int NUM_COEFFS = 12,
  parameter int DATA_WIDTH = 16,
  parameter int LOG_FRAMES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            mode_in,
  input  logic [DATA_WIDTH-1:0] dct_data_in,
  input  logic                  dct_valid_in,
  input  logic                  dct_last_in,
  output logic                  dct_ready_out,
  input  logic                  feature_ready_in,
  output logic                  feature_valid_out,
  output logic [31:0]           feature_data_out,
`ifdef FEATURE_LAST_EN
  output logic                  feature_last_out,
`endif
  output logic                  frame_error_out
);

  localparam int IW = clog2_min1(N_DCT);
  localparam int SW = clog2_min1(NUM_COEFFS);
  localparam int AW = DATA_WIDTH + LOG_FRAMES;
  localparam int CW = LOG_FRAMES + 1;

  localparam logic [IW-1:0] FIRST_I  = IW'(FIRST_COEF);
  localparam logic [IW-1:0] KEEP_END = IW'(FIRST_COEF + NUM_COEFFS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DCT - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_COEFFS - 1);
  localparam logic [CW-1:0] FULL = CW'(1 << LOG_FRAMES);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   slot;
  logic [SW-1:0]   out_idx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   ncnt;
  logic [1:0]      mode_lat;
  logic [1:0]      prev_mode;
  logic [1:0]      cur_mode;
  logic            beat;
  logic            keep;
  logic            restart;

  logic signed [DATA_WIDTH-1:0] fbuf [NUM_COEFFS];
  logic signed [DATA_WIDTH-1:0] fv   [NUM_COEFFS];
  logic signed [AW-1:0]         acc  [NUM_COEFFS];
  logic signed [AW-1:0]         word;

  assign dct_ready_out     = (state != ST_EMIT);
  assign feature_valid_out = (state == ST_EMIT);
  assign feature_data_out  = feature_valid_out ? 32'(word) : '0;

`ifdef FEATURE_LAST_EN
  assign feature_last_out = feature_valid_out && (out_idx == LAST_SLOT);
`endif

  // Beat decode, kept-window test and the frame as it would stand after this beat
  always_comb begin
    beat     = dct_valid_in && dct_ready_out;
    keep     = (idx >= FIRST_I) && (idx <= KEEP_END);
    slot     = SW'(idx - FIRST_I);
    cur_mode = (idx == '0) ? mode_in : mode_lat;
    restart  = (prev_mode != MODE_AVERAGE) || (cnt == '0);
    ncnt     = restart ? CW'(1) : cnt + CW'(1);
    for (int i = 0; i < NUM_COEFFS; i++) begin
      fv[i] = (keep && slot == SW'(i)) ? dct_data_in : fbuf[i];
    end
    word = (mode_lat == MODE_AVERAGE) ? (acc[out_idx] >>> LOG_FRAMES)
                                      : acc[out_idx];
  end

  // Frame sequencing, accumulation and output word stepping
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= ST_COLLECT;
      idx             <= '0;
      cnt             <= '0;
      mode_lat        <= MODE_OFF;
      prev_mode       <= MODE_OFF;
      out_idx         <= '0;
      frame_error_out <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        acc[i]  <= '0;
        fbuf[i] <= '0;
      end
    end else begin
      frame_error_out <= 1'b0;
      unique case (state)
        ST_COLLECT: begin
          if (beat) begin
            if (idx == '0) mode_lat <= mode_in;
            if (keep) fbuf[slot] <= dct_data_in;
            if (dct_last_in && idx != LAST_IDX) begin
              frame_error_out <= 1'b1;
              idx             <= '0;
            end else if (!dct_last_in && idx == LAST_IDX) begin
              frame_error_out <= 1'b1;
              idx             <= '0;
              state           <= ST_DRAIN;
            end else if (idx == LAST_IDX) begin
              idx       <= '0;
              prev_mode <= cur_mode;
              unique case (cur_mode)
                MODE_STREAM: begin
                  for (int i = 0; i < NUM_COEFFS; i++)
                    acc[i] <= AW'(fv[i]);
                  cnt   <= '0;
                  state <= ST_EMIT;
                end
                MODE_AVERAGE: begin
                  for (int i = 0; i < NUM_COEFFS; i++)
                    acc[i] <= restart ? AW'(fv[i])
                                      : acc[i] + AW'(fv[i]);
                  cnt <= ncnt;
                  if (ncnt == FULL) state <= ST_EMIT;
                end
                default: cnt <= '0;
              endcase
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (beat && dct_last_in) state <= ST_COLLECT;
        end
        ST_EMIT: begin
          if (feature_ready_in) begin
            if (out_idx == LAST_SLOT) begin
              out_idx <= '0;
              cnt     <= '0;
              state   <= ST_COLLECT;
              for (int i = 0; i < NUM_COEFFS; i++) acc[i] <= '0;
            end else begin
              out_idx <= out_idx + SW'(1);
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_aggregator.sv
// Directed bench for feature_aggregator.
// Builds with or without FEATURE_LAST_EN.
module tb_feature_aggregator;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [1:0]  mode_in;
  logic [15:0] dct_data_in;
  logic        dct_valid_in;
  logic        dct_last_in;
  logic        dct_ready_out;
  logic        feature_ready_in;
  logic        feature_valid_out;
  logic [31:0] feature_data_out;
  logic        frame_error_out;
`ifdef FEATURE_LAST_EN
  logic        feature_last_out;
`endif

  int total = 0;
  int bad   = 0;
  int errs  = 0;
  int coef [64];
  int outq [$];

  always #5 clk_in = ~clk_in;

  feature_aggregator dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .mode_in           (mode_in),
    .dct_data_in       (dct_data_in),
    .dct_valid_in      (dct_valid_in),
    .dct_last_in       (dct_last_in),
    .dct_ready_out     (dct_ready_out),
    .feature_ready_in  (feature_ready_in),
    .feature_valid_out (feature_valid_out),
    .feature_data_out  (feature_data_out),
`ifdef FEATURE_LAST_EN
    .feature_last_out  (feature_last_out),
`endif
    .frame_error_out   (frame_error_out)
  );

  always @(posedge clk_in) begin
    if (!rst_in && feature_valid_out && feature_ready_in)
      outq.push_back(int'($signed(feature_data_out)));
    if (!rst_in && frame_error_out)
      errs++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [1:0] m, input int nb,
                            input int lastpos);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk_in);
      dct_valid_in = 1'b1;
      dct_data_in  = 16'(coef[i]);
      dct_last_in  = (i == lastpos);
      mode_in      = m;
      @(posedge clk_in);
    end
    #1;
    dct_valid_in = 1'b0;
    dct_last_in  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (feature_valid_out && n < 300) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic fill(input int mul, input int add);
    for (int i = 0; i < 64; i++) coef[i] = i * mul + add;
  endtask

  int e0;
  int bad_rdy;

  initial begin
    rst_in           = 1'b1;
    mode_in          = 2'b00;
    dct_data_in      = '0;
    dct_valid_in     = 1'b0;
    dct_last_in      = 1'b0;
    feature_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    chk("rst_valid", int'(feature_valid_out), 0);
    chk("rst_data",  int'(feature_data_out), 0);
    chk("rst_err",   int'(frame_error_out), 0);
    chk("rst_ready", int'(dct_ready_out), 1);

    // stream mode, coef i = i*10
    fill(10, 0);
    send_frame(2'b01, 32, 31);
    chk("stream_valid_next", int'(feature_valid_out), 1);
    wait_idle();
    chk("stream_count", outq.size(), 12);
    for (int k = 0; k < 12; k++)
      chk($sformatf("stream_w%0d", k),
          (k < outq.size()) ? outq[k] : -99999, 10 * (k + 1));
    outq.delete();

    // average mode, four frames
    fill(0, 0);
    coef[1] = 4;  coef[2] = 1; coef[3] = -1;
    send_frame(2'b10, 32, 31);
    coef[1] = 5;
    send_frame(2'b10, 32, 31);
    coef[1] = 6;
    send_frame(2'b10, 32, 31);
    repeat (3) @(posedge clk_in);
    #1;
    chk("avg_no_early_out", outq.size(), 0);
    chk("avg_no_early_valid", int'(feature_valid_out), 0);
    coef[1] = -7; coef[2] = 2; coef[3] = -2;
    send_frame(2'b10, 32, 31);
    chk("avg_valid_next", int'(feature_valid_out), 1);
    wait_idle();
    chk("avg_count", outq.size(), 12);
    if (outq.size() == 12) begin
      chk("avg_w0", outq[0], 2);
      chk("avg_w1", outq[1], 1);
      chk("avg_w2", outq[2], -2);
      chk("avg_w11", outq[11], 0);
    end
    outq.delete();

    // early last at index 20
    fill(10, 0);
    e0 = errs;
    send_frame(2'b01, 21, 20);
    repeat (3) @(posedge clk_in);
    #1;
    chk("short_err", errs - e0, 1);
    chk("short_no_out", outq.size(), 0);
    send_frame(2'b01, 32, 31);
    wait_idle();
    chk("short_next_count", outq.size(), 12);
    if (outq.size() == 12) begin
      chk("short_next_w0", outq[0], 10);
      chk("short_next_w11", outq[11], 120);
    end
    outq.delete();

    // over-long frame: 34 beats, last on beat 34
    fill(3, 0);
    e0 = errs;
    send_frame(2'b01, 34, 33);
    repeat (3) @(posedge clk_in);
    #1;
    chk("long_err", errs - e0, 1);
    chk("long_no_out", outq.size(), 0);
    fill(1, 100);
    send_frame(2'b01, 32, 31);
    wait_idle();
    chk("long_next_count", outq.size(), 12);
    if (outq.size() == 12) begin
      chk("long_next_w0", outq[0], 101);
      chk("long_next_w11", outq[11], 112);
    end
    outq.delete();

    // back-pressure 1,0,0,1 during emit
    fill(10, 0);
    feature_ready_in = 1'b1;
    send_frame(2'b01, 32, 31);
    chk("stall_w0", int'(feature_data_out), 10);
    @(posedge clk_in);
    #1;
    feature_ready_in = 1'b0;
    chk("stall_a_data", int'(feature_data_out), 20);
    chk("stall_a_ready", int'(dct_ready_out), 0);
    @(posedge clk_in);
    #1;
    chk("stall_b_data", int'(feature_data_out), 20);
    chk("stall_b_valid", int'(feature_valid_out), 1);
    @(posedge clk_in);
    #1;
    chk("stall_c_data", int'(feature_data_out), 20);
    feature_ready_in = 1'b1;
    bad_rdy = 0;
    for (int n = 0; n < 40 && feature_valid_out; n++) begin
      if (dct_ready_out) bad_rdy++;
      @(posedge clk_in);
      #1;
    end
    chk("stall_ready_low", bad_rdy, 0);
    wait_idle();
    chk("stall_count", outq.size(), 12);
    if (outq.size() == 12) begin
      chk("stall_w1", outq[1], 20);
      chk("stall_w2", outq[2], 30);
    end
    outq.delete();

    // reset in the middle of an emit
    feature_ready_in = 1'b0;
    send_frame(2'b01, 32, 31);
    chk("pre_rst_valid", int'(feature_valid_out), 1);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    feature_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("post_rst_valid", int'(feature_valid_out), 0);
    chk("post_rst_ready", int'(dct_ready_out), 1);
    fill(0, 8);
    send_frame(2'b10, 32, 31);
    send_frame(2'b10, 32, 31);
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_two_frames_no_out", outq.size(), 0);
    send_frame(2'b10, 32, 31);
    send_frame(2'b10, 32, 31);
    wait_idle();
    chk("rst_avg_count", outq.size(), 12);
    if (outq.size() == 12) begin
      chk("rst_avg_w0", outq[0], 8);
      chk("rst_avg_w11", outq[11], 8);
    end
    outq.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
